// File: rtl/tap_csa_mac_pkg.sv
// tap_csa_mac_pkg: shared widths, parameter defaults and FSM states for the tap MAC.
package tap_csa_mac_pkg;
    localparam int N_TAPS_D = 4;
    localparam int FRAC_D = 9;
    localparam int XW = 10;
    localparam int WW = 10;
    localparam int ACCW = 11;
    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;
endpackage

// File: rtl/tap_csa_mac_csa3.sv
// csa3: combinational 3:2 compressor producing a carry-save sum/carry pair.
module csa3
    import tap_csa_mac_pkg::*;
(
    input  logic [ACCW-1:0] i_a,
    input  logic [ACCW-1:0] i_b,
    input  logic [ACCW-1:0] i_c,
    output logic [ACCW-1:0] o_sum,
    output logic [ACCW-1:0] o_carry
);
    assign o_sum = i_a ^ i_b ^ i_c;
    assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;
endmodule

// File: rtl/tap_csa_mac.sv
// tap_csa_mac: one-tap-per-cycle FIR MAC whose accumulator is kept in carry-save form.
module tap_csa_mac
    import tap_csa_mac_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_D,
    parameter int FRAC = FRAC_D
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XW-1:0]             x_in,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic                      w_we,
    input  logic [$clog2(N_TAPS)-1:0] w_addr,
    input  logic [WW-1:0]             w_data,
    output logic [ACCW-1:0]           sum,
    output logic [ACCW-1:0]           carry,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int AW = $clog2(N_TAPS);

    state_t r_state, w_next;
    logic signed [XW-1:0] r_x [N_TAPS];
    logic signed [WW-1:0] r_w [N_TAPS];
    logic [AW-1:0] r_cnt;
    logic [ACCW-1:0] r_sum, r_carry;
    logic signed [XW+WW-1:0] w_prod;
    logic [ACCW-1:0] w_term, w_csa_s, w_csa_c;
    logic w_accept, w_last;

    assign x_ready = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign w_accept = x_ready && x_valid;
    assign w_last = (r_cnt == AW'(N_TAPS - 1));
    assign w_prod = r_x[r_cnt] * r_w[r_cnt];
    assign w_term = ACCW'(w_prod >>> FRAC);
    assign sum = r_sum;
    assign carry = r_carry;

    csa3 u_csa3 (
        .i_a(r_sum),
        .i_b(r_carry),
        .i_c(w_term),
        .o_sum(w_csa_s),
        .o_carry(w_csa_c)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = x_valid ? MAC : IDLE;
            MAC: w_next = w_last ? HOLD : MAC;
            HOLD: w_next = out_ready ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // A weight written alongside an accept is visible to that sample, since MAC starts next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_carry <= '0;
            for (int k = 0; k < N_TAPS; k++) begin
                r_x[k] <= '0;
                r_w[k] <= '0;
            end
        end else begin
            if (x_ready && w_we) r_w[w_addr] <= w_data;
            if (w_accept) begin
                r_x[0] <= x_in;
                for (int k = 1; k < N_TAPS; k++) r_x[k] <= r_x[k-1];
                r_cnt <= '0;
                r_sum <= '0;
                r_carry <= '0;
            end else if (r_state == MAC) begin
                r_sum <= w_csa_s;
                r_carry <= w_csa_c;
                r_cnt <= w_last ? r_cnt : r_cnt + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_tap_csa_mac.sv
// tb_tap_csa_mac: directed vectors plus a per-cycle check against a behavioural FIR model.
module tb_tap_csa_mac;
    logic clk = 0, rst = 0, x_valid = 0, w_we = 0, out_ready = 0;
    logic [9:0] x_in = 0, w_data = 0;
    logic [1:0] w_addr = 0;
    logic x_ready, out_valid;
    logic [10:0] sum, carry;
    int checks = 0, failures = 0;

    int mx [4];
    int mw [4];
    int m_mode = 0, m_left = 0, m_exp = 0;
    bit m_init = 0, m_zero = 0, m_first = 0;
    logic [10:0] h_sum, h_carry;

    tap_csa_mac dut (
        .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .sum(sum), .carry(carry),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 computing (m_left edges to go), 2 holding a result.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin mx[k] = 0; mw[k] = 0; end
            m_mode = 0; m_left = 0; m_init = 1; m_zero = 1;
        end else if (m_mode == 0) begin
            if (w_we) mw[w_addr] = int'($signed(w_data));
            if (x_valid) begin
                for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = int'($signed(x_in));
                m_exp = 0;
                for (int k = 0; k < 4; k++) m_exp += (mx[k] * mw[k]) >>> 9;
                m_exp = m_exp & 2047;
                m_mode = 1; m_left = 4; m_zero = 0;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin m_mode = 2; m_first = 1; end
        end else if (out_ready) m_mode = 0;
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("x_ready", int'(x_ready), int'(m_mode == 0));
            chk("out_valid", int'(out_valid), int'(m_mode == 2));
            if (m_mode == 0 && m_zero) begin
                chk("sum_zero", int'(sum), 0);
                chk("carry_zero", int'(carry), 0);
            end
            if (m_mode == 2) begin
                chk("result_model", int'((sum + carry) & 11'h7ff), m_exp);
                if (m_first) begin
                    h_sum = sum; h_carry = carry; m_first = 0;
                end else begin
                    chk("hold_sum", int'(sum), int'(h_sum));
                    chk("hold_carry", int'(carry), int'(h_carry));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic write_w(input int a, input int d);
        w_we = 1; w_addr = 2'(a); w_data = 10'(d);
        step();
        w_we = 0;
    endtask

    task automatic send(input int x);
        x_valid = 1; x_in = 10'(x);
        step();
        x_valid = 0;
    endtask

    task automatic wait_result(input string name, input int lit, input bit release_it);
        int n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk({name, "_latency"}, n, 4);
        chk({name, "_value"}, int'((sum + carry) & 11'h7ff), lit);
        chk({name, "_model"}, m_exp, lit);
        if (release_it) begin
            out_ready = 1; step(); out_ready = 0;
            chk({name, "_released"}, int'(x_ready), 1);
        end
    endtask

    initial begin
        rst = 1; step(); step(); rst = 0;
        chk("rst_sum", int'(sum), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_x_ready", int'(x_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);

        send(123); wait_result("zero_w", 0, 1);
        write_w(0, 256); send(100); wait_result("w0_x100", 50, 1);
        write_w(1, 256); send(200); wait_result("two_taps", 150, 1);
        write_w(1, 0); send(-100); wait_result("neg_x", 1998, 1);

        send(100); wait_result("hold", 50, 0);
        w_we = 1; w_addr = 0; w_data = 5; x_valid = 1; x_in = 10'd77;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_x_ready", int'(x_ready), 0);
        end
        w_we = 0; x_valid = 0; out_ready = 1; step(); out_ready = 0;
        chk("hold_exit_valid", int'(out_valid), 0);
        chk("hold_exit_ready", int'(x_ready), 1);
        send(100); wait_result("w_ignored", 50, 1);

        w_we = 1; w_addr = 1; w_data = 10'd256; x_valid = 1; x_in = 10'd10;
        step();
        w_we = 0; x_valid = 0;
        wait_result("same_cycle_w", 55, 1);
        write_w(1, 0);

        write_w(0, -512); send(-512); wait_result("extreme", 512, 1);
        write_w(0, -512); send(511); wait_result("extreme_neg", 1537, 1);

        write_w(0, 256); send(100); step();
        rst = 1; step();
        chk("mid_rst_sum", int'(sum), 0);
        chk("mid_rst_carry", int'(carry), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_ready", int'(x_ready), 1);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_no_pulse", int'(out_valid), 0);
        end
        write_w(0, 256); send(100); wait_result("after_rst", 50, 1);

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
